// File: rtl/field_lock_pkg.sv
// Shared definitions for the field/vsync lock monitor: lock-state encoding,
// the modular signed distance helper and the parameter legality check.
package field_lock_pkg;

   typedef enum logic [1:0] {
      LS_UNLOCKED = 2'd0,
      LS_ACQUIRE  = 2'd1,
      LS_LOCKED   = 2'd2,
      LS_LOST     = 2'd3
   } lock_state_t;

   // |a - b| where a, b and the difference are treated as w-bit two's
   // complement values (w <= 32); operands arrive zero-extended to 32 bits.
   function automatic logic [31:0] lock_abs_diff(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input int unsigned w);
      logic [31:0] mask;
      logic [31:0] diff;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      diff = (a - b) & mask;
      if (((diff >> (w - 1)) & 32'd1) != 32'd0)
         diff = ((~diff) + 32'd1) & mask;
      return diff;
   endfunction

   function automatic bit field_lock_params_ok(input int cnt_w,
                                               input int sync_stages,
                                               input int num_evt,
                                               input int lock_windows,
                                               input int slip_max,
                                               input int vs_timeout);
      return (cnt_w >= 4) && (cnt_w <= 32) &&
             (sync_stages >= 2) &&
             (num_evt >= 1) && (num_evt <= 16) &&
             (lock_windows >= 1) && (lock_windows <= 255) &&
             (slip_max >= 0) && (vs_timeout >= 1);
   endfunction

endpackage

// File: rtl/field_lock_monitor_toggle_edge_sync.sv
// Brings an asynchronous toggle into the destination clock and turns each
// toggle into a one-cycle edge pulse. The chain holds one register beyond
// the synchroniser depth; the pulse is the XOR of the last two registers.
module toggle_edge_sync
   import field_lock_pkg::*;
#(
   parameter int SYNC_STAGES = 3
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_toggle,
   output logic o_edge
);

   logic [SYNC_STAGES:0] r_sync;

   // Shift the toggle level through the synchroniser and edge-detect delay
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-1:0], i_toggle};
   end

   assign o_edge = r_sync[SYNC_STAGES] ^ r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/field_lock_monitor.sv
// Input-field vs output-frame lock monitor in the camera pixel clock domain.
// Counts field and vsync edges, tracks their modular difference, latches
// per-frame event flags and runs the UNLOCKED/ACQUIRE/LOCKED/LOST machine.
module field_lock_monitor
   import field_lock_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int SYNC_STAGES  = 3,
   parameter int NUM_EVT      = 4,
   parameter int LOCK_WINDOWS = 8,
   parameter int SLIP_MAX     = 1,
   parameter int VS_TIMEOUT   = 1_000_000
) (
   input  logic               cam1_pclk,
   input  logic               cam_resetn,
   input  logic               cam_field_toggle,
   input  logic               vsync_toggle_pix,
   input  logic [NUM_EVT-1:0] evt_in,
   input  logic               clr,
   output logic [CNT_W-1:0]   in_sof_cnt,
   output logic [CNT_W-1:0]   out_vsync_cnt,
   output logic [CNT_W-1:0]   sof_delta,
   output logic [NUM_EVT-1:0] evt_window,
   output logic [NUM_EVT-1:0] evt_sticky,
   output logic [1:0]         lock_state,
   output logic               locked,
   output logic [CNT_W-1:0]   slip_cnt
);

   localparam int TO_W = $clog2(VS_TIMEOUT + 1);

   if (!field_lock_params_ok(CNT_W, SYNC_STAGES, NUM_EVT, LOCK_WINDOWS,
                             SLIP_MAX, VS_TIMEOUT)) begin : g_param_error
      $error("field_lock_monitor: illegal parameter set");
   end

   logic               r_tog_d;
   logic [CNT_W-1:0]   r_sof, r_vs, r_delta, r_ref, r_slip;
   logic [NUM_EVT-1:0] r_acc, r_evtw, r_sticky;
   logic [7:0]         r_good;
   logic [TO_W-1:0]    r_to;
   lock_state_t        r_state, w_state_n;
   logic               r_locked;

   logic               w_fedge, w_vedge, w_good, w_to_hit;
   logic [CNT_W-1:0]   w_sof_n, w_vs_n, w_delta_n;
   logic [31:0]        w_absd;
   logic               w_ref_load, w_good_inc, w_slip_inc;

   toggle_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vs_sync (
      .i_clk    (cam1_pclk),
      .i_rst_n  (cam_resetn),
      .i_toggle (vsync_toggle_pix),
      .o_edge   (w_vedge)
   );

   // Post-edge counts: a field and a vsync edge in the same cycle both count
   assign w_fedge   = cam_field_toggle ^ r_tog_d;
   assign w_sof_n   = r_sof + CNT_W'(w_fedge);
   assign w_vs_n    = r_vs + CNT_W'(w_vedge);
   assign w_delta_n = w_sof_n - w_vs_n;
   assign w_absd    = lock_abs_diff(32'(w_delta_n), 32'(r_ref), CNT_W);
   assign w_good    = (w_absd <= 32'(SLIP_MAX));
   assign w_to_hit  = (r_state == LS_LOCKED) && !w_vedge &&
                      (r_to == TO_W'(VS_TIMEOUT - 1));

   // Field toggle delay; on clear it follows the input so no false edge appears
   always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
      if (!cam_resetn) r_tog_d <= 1'b0;
      else             r_tog_d <= cam_field_toggle;
   end

   // Edge counters and the registered difference
   always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
      if (!cam_resetn) begin
         r_sof   <= '0;
         r_vs    <= '0;
         r_delta <= '0;
      end else if (clr) begin
         r_sof   <= '0;
         r_vs    <= '0;
         r_delta <= '0;
      end else begin
         r_sof   <= w_sof_n;
         r_vs    <= w_vs_n;
         r_delta <= w_delta_n;
      end
   end

   // Event accumulation; an event in the edge cycle closes with its window
   always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
      if (!cam_resetn) begin
         r_acc    <= '0;
         r_evtw   <= '0;
         r_sticky <= '0;
      end else if (clr) begin
         r_acc    <= '0;
         r_evtw   <= '0;
         r_sticky <= '0;
      end else begin
         r_sticky <= r_sticky | evt_in;
         if (w_vedge) begin
            r_evtw <= r_acc | evt_in;
            r_acc  <= '0;
         end else begin
            r_acc  <= r_acc | evt_in;
         end
      end
   end

   // Lock state register
   always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
      if (!cam_resetn) begin
         r_state  <= LS_UNLOCKED;
         r_locked <= 1'b0;
      end else if (clr) begin
         r_state  <= LS_UNLOCKED;
         r_locked <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_locked <= (w_state_n == LS_LOCKED);
      end
   end

   // Lock next-state: window decisions on vsync edges, timeout otherwise
   always_comb begin
      w_state_n = r_state;
      if (w_vedge) begin
         case (r_state)
            LS_UNLOCKED: w_state_n = LS_ACQUIRE;
            LS_ACQUIRE:  if (w_good && (r_good == 8'(LOCK_WINDOWS - 1)))
                            w_state_n = LS_LOCKED;
            LS_LOCKED:   if (!w_good) w_state_n = LS_LOST;
            LS_LOST:     w_state_n = LS_ACQUIRE;
            default:     w_state_n = LS_UNLOCKED;
         endcase
      end else if (w_to_hit) begin
         w_state_n = LS_LOST;
      end
   end

   // Lock outputs: reference reload, good-window count and slip strobes
   always_comb begin
      w_ref_load = w_vedge && ((r_state == LS_UNLOCKED) || (r_state == LS_LOST) ||
                               ((r_state == LS_ACQUIRE) && !w_good));
      w_good_inc = w_vedge && (r_state == LS_ACQUIRE) && w_good;
      w_slip_inc = (r_state == LS_LOCKED) && ((w_vedge && !w_good) || w_to_hit);
   end

   // Reference delta, good-window count and saturating slip count
   always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
      if (!cam_resetn) begin
         r_ref  <= '0;
         r_good <= '0;
         r_slip <= '0;
      end else if (clr) begin
         r_ref  <= '0;
         r_good <= '0;
         r_slip <= '0;
      end else begin
         if (w_ref_load) begin
            r_ref  <= w_delta_n;
            r_good <= '0;
         end else if (w_good_inc) begin
            r_good <= r_good + 8'd1;
         end
         if (w_slip_inc && (r_slip != '1)) r_slip <= r_slip + CNT_W'(1);
      end
   end

   // Vsync-absence timer: runs only while locked, cleared by every vsync edge
   always_ff @(posedge cam1_pclk or negedge cam_resetn) begin
      if (!cam_resetn)                           r_to <= '0;
      else if (clr)                              r_to <= '0;
      else if (w_vedge || (r_state != LS_LOCKED)) r_to <= '0;
      else if (r_to != TO_W'(VS_TIMEOUT))         r_to <= r_to + TO_W'(1);
   end

   assign in_sof_cnt    = r_sof;
   assign out_vsync_cnt = r_vs;
   assign sof_delta     = r_delta;
   assign evt_window    = r_evtw;
   assign evt_sticky    = r_sticky;
   assign lock_state    = r_state;
   assign locked        = r_locked;
   assign slip_cnt      = r_slip;

endmodule

// File: tb/tb_field_lock_monitor.sv
// Directed bench for field_lock_monitor with a window scoreboard.
module tb_field_lock_monitor;

   localparam int CW = 4;
   localparam int SS = 3;
   localparam int NE = 4;
   localparam int LW = 8;
   localparam int SM = 1;
   localparam int VT = 500;

   localparam logic [1:0] S_UNL = 2'd0;
   localparam logic [1:0] S_ACQ = 2'd1;
   localparam logic [1:0] S_LCK = 2'd2;
   localparam logic [1:0] S_LST = 2'd3;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic          ftog = 1'b0;
   logic          vtog = 1'b0;
   logic          clr  = 1'b0;
   logic [NE-1:0] evt  = '0;

   logic [CW-1:0] in_sof_cnt, out_vsync_cnt, sof_delta, slip_cnt;
   logic [NE-1:0] evt_window, evt_sticky;
   logic [1:0]    lock_state;
   logic          locked;

   always #5 clk = ~clk;

   field_lock_monitor #(
      .CNT_W(CW), .SYNC_STAGES(SS), .NUM_EVT(NE), .LOCK_WINDOWS(LW),
      .SLIP_MAX(SM), .VS_TIMEOUT(VT)
   ) dut (
      .cam1_pclk        (clk),
      .cam_resetn       (rstn),
      .cam_field_toggle (ftog),
      .vsync_toggle_pix (vtog),
      .evt_in           (evt),
      .clr              (clr),
      .in_sof_cnt       (in_sof_cnt),
      .out_vsync_cnt    (out_vsync_cnt),
      .sof_delta        (sof_delta),
      .evt_window       (evt_window),
      .evt_sticky       (evt_sticky),
      .lock_state       (lock_state),
      .locked           (locked),
      .slip_cnt         (slip_cnt)
   );

   typedef struct {
      logic [CW-1:0] sof;
      logic [CW-1:0] vs;
      logic [CW-1:0] delta;
      logic [1:0]    st;
      logic [CW-1:0] slip;
      logic [NE-1:0] evtw;
   } exp_t;

   exp_t sb[$];

   logic [CW-1:0] m_sof = '0, m_vs = '0, m_ref = '0, m_slip = '0;
   logic [1:0]    m_st = S_UNL;
   int            m_good = 0;
   logic [NE-1:0] m_acc = '0, m_sticky = '0;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic field_tog();
      ftog = ~ftog;
      m_sof++;
      tick(1);
   endtask

   task automatic evt_pulse(input logic [NE-1:0] e);
      evt = e;
      m_acc |= e;
      m_sticky |= e;
      tick(1);
      evt = '0;
   endtask

   // Reference behaviour of one window close, pushed as the expected result
   task automatic model_window();
      logic [CW-1:0]        d;
      logic signed [CW-1:0] df;
      int                   ad;
      bit                   good;
      m_vs++;
      d    = m_sof - m_vs;
      df   = d - m_ref;
      ad   = (df < 0) ? -int'(df) : int'(df);
      good = (ad <= SM);
      case (m_st)
         S_UNL: begin m_st = S_ACQ; m_ref = d; m_good = 0; end
         S_ACQ: begin
            if (good) begin
               m_good++;
               if (m_good == LW) m_st = S_LCK;
            end else begin
               m_good = 0;
               m_ref  = d;
            end
         end
         S_LCK: if (!good) begin
            m_st = S_LST;
            if (m_slip != '1) m_slip++;
         end
         default: begin m_st = S_ACQ; m_ref = d; m_good = 0; end
      endcase
      sb.push_back('{m_sof, m_vs, d, m_st, m_slip, m_acc});
      m_acc = '0;
   endtask

   // Toggle vsync; optional event and field toggle land in the edge cycle
   task automatic vsync_tog(input logic [NE-1:0] e, input bit f_at_edge);
      vtog = ~vtog;
      tick(SS);
      if (f_at_edge) begin
         ftog = ~ftog;
         m_sof++;
      end
      evt = e;
      m_acc |= e;
      m_sticky |= e;
      model_window();
      tick(1);
      evt = '0;
   endtask

   logic [CW-1:0] prev_vs = '0;
   bit            mon_en  = 1'b0;

   always @(negedge clk) begin
      if (mon_en && (out_vsync_cnt !== prev_vs)) begin : mon
         exp_t e;
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("win_sof",    in_sof_cnt,    e.sof);
            chk("win_vs",     out_vsync_cnt, e.vs);
            chk("win_delta",  sof_delta,     e.delta);
            chk("win_state",  lock_state,    e.st);
            chk("win_locked", locked,        (e.st == S_LCK));
            chk("win_slip",   slip_cnt,      e.slip);
            chk("win_evtw",   evt_window,    e.evtw);
            chk("win_sticky", evt_sticky,    m_sticky);
         end
      end
      prev_vs <= out_vsync_cnt;
   end

   initial begin
      // Reset state
      tick(3);
      chk("rst_sof",    in_sof_cnt,    0);
      chk("rst_vs",     out_vsync_cnt, 0);
      chk("rst_delta",  sof_delta,     0);
      chk("rst_evtw",   evt_window,    0);
      chk("rst_sticky", evt_sticky,    0);
      chk("rst_state",  lock_state,    S_UNL);
      chk("rst_locked", locked,        0);
      chk("rst_slip",   slip_cnt,      0);
      rstn = 1'b1;
      tick(2);
      mon_en = 1'b1;

      // Acquisition: one field and one vsync per window
      for (int i = 0; i < 10; i++) begin
         field_tog();
         tick(99);
         vsync_tog('0, 1'b0);
         if (i == 7) chk("acq_before_lock", lock_state, S_ACQ);
         if (i == 8) chk("lock_after_9th",  lock_state, S_LCK);
      end
      chk("acq_sof",    in_sof_cnt,    10);
      chk("acq_vs",     out_vsync_cnt, 10);
      chk("acq_delta",  sof_delta,     0);
      chk("acq_locked", locked,        1);

      // Two extra field toggles in one window break lock
      field_tog(); tick(5);
      field_tog(); tick(5);
      field_tog(); tick(80);
      vsync_tog('0, 1'b0);
      chk("slip_state",  lock_state, S_LST);
      chk("slip_cnt",    slip_cnt,   1);
      chk("slip_locked", locked,     0);
      field_tog();
      tick(99);
      vsync_tog('0, 1'b0);
      chk("lost_to_acq", lock_state, S_ACQ);

      // Field and vsync edges in the same cycle
      tick(99);
      vsync_tog('0, 1'b1);
      chk("same_delta", sof_delta,  2);
      chk("same_state", lock_state, S_ACQ);

      // Event in the vsync-edge cycle belongs to the closing window
      field_tog();
      tick(99);
      vsync_tog(4'b0100, 1'b0);
      chk("evt_edge_win",    evt_window, 4'b0100);
      chk("evt_edge_sticky", evt_sticky, 4'b0100);
      field_tog();
      tick(99);
      vsync_tog('0, 1'b0);
      chk("evt_next_win",    evt_window, 4'b0000);
      chk("evt_next_sticky", evt_sticky, 4'b0100);

      // Re-lock, with a mid-window event on the first window
      for (int i = 0; i < 5; i++) begin
         field_tog();
         tick(49);
         if (i == 0) evt_pulse(4'b0010);
         tick(49);
         vsync_tog('0, 1'b0);
      end
      chk("relock_locked", locked,     1);
      chk("relock_sticky", evt_sticky, 4'b0110);

      // Vsync stops: LOST exactly VS_TIMEOUT cycles after the last edge
      tick(VT - 1);
      chk("to_before", lock_state, S_LCK);
      tick(1);
      m_st = S_LST;
      m_slip++;
      chk("to_state",  lock_state, m_st);
      chk("to_slip",   slip_cnt,   m_slip);
      chk("to_locked", locked,     0);

      // Clear returns everything to the reset state
      mon_en = 1'b0;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
      m_sof = '0; m_vs = '0; m_ref = '0; m_slip = '0;
      m_st = S_UNL; m_good = 0; m_acc = '0; m_sticky = '0;
      chk("clr_sof",    in_sof_cnt,    0);
      chk("clr_vs",     out_vsync_cnt, 0);
      chk("clr_delta",  sof_delta,     0);
      chk("clr_state",  lock_state,    S_UNL);
      chk("clr_slip",   slip_cnt,      0);
      chk("clr_sticky", evt_sticky,    0);
      chk("clr_evtw",   evt_window,    0);
      mon_en = 1'b1;

      // Counter wrap: 17 field toggles with no vsync
      for (int i = 0; i < 17; i++) begin
         field_tog();
         tick(1);
      end
      chk("wrap_sof",   in_sof_cnt,    m_sof);
      chk("wrap_sof1",  in_sof_cnt,    1);
      chk("wrap_vs",    out_vsync_cnt, 0);
      chk("wrap_delta", sof_delta,     1);
      chk("wrap_state", lock_state,    S_UNL);

      tick(10);
      chk("sb_drain", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
